// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pkg
//  Description : Shared constants for the servo PWM bank (default frame
//                timing and pulse limits) and the pulse-width clamp rule.
//  Revision    : 1.0 - initial release
// ============================================================================
package servo_pkg;

    // Defaults assume a 50 MHz clock and a 20 ms servo frame.
    localparam int c_DEF_PERIOD_CYC = 1_000_000;
    localparam int c_DEF_MIN_CYC    = 50_000;
    localparam int c_DEF_MID_CYC    = 150_000;
    localparam int c_DEF_MAX_CYC    = 250_000;
    localparam int c_DEF_STEP_CYC   = 5_000;

    // Saturate a requested pulse width into [i_lo, i_hi].
    function automatic logic [31:0] clamp_cyc(
        input logic [31:0] i_val,
        input logic [31:0] i_lo,
        input logic [31:0] i_hi
    );
        logic [31:0] v_res;
        v_res = i_val;
        if (i_val < i_lo) begin
            v_res = i_lo;
        end else if (i_val > i_hi) begin
            v_res = i_hi;
        end
        return v_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_slew_ch.sv
`default_nettype none
// ============================================================================
//  Module      : servo_slew_ch
//  Description : One servo channel: clamped target register, slew-limited
//                current width updated once per frame, and the registered
//                PWM compare against the shared frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module servo_slew_ch
    import servo_pkg::*;
#(
    parameter int CW       = 21,
    parameter int MIN_CYC  = c_DEF_MIN_CYC,
    parameter int MAX_CYC  = c_DEF_MAX_CYC,
    parameter int MID_CYC  = c_DEF_MID_CYC,
    parameter int STEP_CYC = c_DEF_STEP_CYC
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr,
    input  logic [CW-1:0] i_wr_data,
    input  logic          i_boundary,
    input  logic [CW-1:0] i_cnt_nxt,
    input  logic          i_en_nxt,
    output logic          o_pwm,
    output logic          o_busy
);

    localparam logic [CW-1:0] c_MID  = CW'(MID_CYC);
    localparam logic [CW-1:0] c_STEP = CW'(STEP_CYC);

    logic [CW-1:0] r_tgt;
    logic [CW-1:0] r_cur;
    logic [CW-1:0] w_cur_nxt;
    logic [CW-1:0] w_diff;
    logic [CW-1:0] w_tgt_clamped;
    logic          r_pwm;

    assign w_tgt_clamped = CW'(clamp_cyc(32'(i_wr_data), 32'(MIN_CYC), 32'(MAX_CYC)));

    // Slew step toward the (pre-write) target at a frame boundary; the
    // difference is taken only in the non-negative direction so nothing wraps.
    always_comb begin
        w_cur_nxt = r_cur;
        w_diff    = '0;
        if (i_boundary) begin
            if (r_tgt > r_cur) begin
                w_diff    = r_tgt - r_cur;
                w_cur_nxt = (w_diff > c_STEP) ? (r_cur + c_STEP) : r_tgt;
            end else if (r_tgt < r_cur) begin
                w_diff    = r_cur - r_tgt;
                w_cur_nxt = (w_diff > c_STEP) ? (r_cur - c_STEP) : r_tgt;
            end
        end
    end

    // Target/current registers and the PWM compare, evaluated on next-cycle
    // counter and enable so the pulse rises together with frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tgt <= c_MID;
            r_cur <= c_MID;
            r_pwm <= 1'b0;
        end else begin
            r_cur <= w_cur_nxt;
            if (i_wr) begin
                r_tgt <= w_tgt_clamped;
            end
            r_pwm <= i_en_nxt & (i_cnt_nxt < w_cur_nxt);
        end
    end

    assign o_pwm  = r_pwm;
    assign o_busy = (r_cur != r_tgt);

endmodule
`default_nettype wire

// File: rtl/servo_pwm_bank.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pwm_bank
//  Description : Bank of NCH slew-limited servo PWM channels sharing one
//                frame counter. Enables are latched only at frame
//                boundaries so no channel ever emits a runt pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_bank
    import servo_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CW         = 21,
    parameter int PERIOD_CYC = c_DEF_PERIOD_CYC,
    parameter int MIN_CYC    = c_DEF_MIN_CYC,
    parameter int MAX_CYC    = c_DEF_MAX_CYC,
    parameter int MID_CYC    = c_DEF_MID_CYC,
    parameter int STEP_CYC   = c_DEF_STEP_CYC
)(
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  wr_en,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch,
    input  logic [CW-1:0]                         wr_data,
    input  logic [NCH-1:0]                        ch_en,
    output logic [NCH-1:0]                        servo,
    output logic                                  frame_start,
    output logic [NCH-1:0]                        busy
);

    localparam logic [CW-1:0] c_LAST = CW'(PERIOD_CYC - 1);

    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           w_boundary;
    logic [NCH-1:0] r_en_q;
    logic [NCH-1:0] w_en_nxt;
    logic [NCH-1:0] w_wr_sel;
    logic           r_frame_start;

    assign w_boundary = (r_cnt == c_LAST);
    assign w_cnt_nxt  = w_boundary ? '0 : (r_cnt + CW'(1));
    assign w_en_nxt   = w_boundary ? ch_en : r_en_q;

    // Shared frame counter, frame-aligned enable latch and frame_start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_en_q        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_en_q        <= w_en_nxt;
            r_frame_start <= w_boundary;
        end
    end

    assign frame_start = r_frame_start;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            // Out-of-range channel indices match no instance and are dropped.
            assign w_wr_sel[i] = wr_en && (int'(wr_ch) == i);

            servo_slew_ch #(
                .CW       (CW),
                .MIN_CYC  (MIN_CYC),
                .MAX_CYC  (MAX_CYC),
                .MID_CYC  (MID_CYC),
                .STEP_CYC (STEP_CYC)
            ) u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_wr       (w_wr_sel[i]),
                .i_wr_data  (wr_data),
                .i_boundary (w_boundary),
                .i_cnt_nxt  (w_cnt_nxt),
                .i_en_nxt   (w_en_nxt[i]),
                .o_pwm      (servo[i]),
                .o_busy     (busy[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servo_pwm_bank
//  Description : Self-checking bench for servo_pwm_bank with a frame-level
//                behavioural reference model and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_bank;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int P    = 100;
    localparam int MINV = 5;
    localparam int MIDV = 15;
    localparam int MAXV = 25;
    localparam int STEP = 4;

    logic           clk     = 1'b0;
    logic           rst_n   = 1'b0;
    logic           wr_en   = 1'b0;
    logic [1:0]     wr_ch   = '0;
    logic [CW-1:0]  wr_data = '0;
    logic [NCH-1:0] ch_en   = 4'hF;
    logic [NCH-1:0] servo;
    logic           frame_start;
    logic [NCH-1:0] busy;

    int checks   = 0;
    int failures = 0;

    servo_pwm_bank #(
        .NCH(NCH), .CW(CW), .PERIOD_CYC(P), .MIN_CYC(MINV),
        .MAX_CYC(MAXV), .MID_CYC(MIDV), .STEP_CYC(STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_data(wr_data), .ch_en(ch_en), .servo(servo),
        .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (frame-level arithmetic) -------------
    int m_cur [NCH];
    int m_tgt [NCH];
    bit m_en  [NCH];
    int m_cnt;
    bit m_fs;

    function automatic int clampv(int v);
        if (v < MINV) return MINV;
        if (v > MAXV) return MAXV;
        return v;
    endfunction

    function automatic int toward(int c, int t);
        if (t > c) return (t - c > STEP) ? c + STEP : t;
        if (t < c) return (c - t > STEP) ? c - STEP : t;
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_fs  <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                m_cur[c] <= MIDV;
                m_tgt[c] <= MIDV;
                m_en[c]  <= 1'b0;
            end
        end else begin
            if (m_cnt == P - 1) begin
                m_cnt <= 0;
                m_fs  <= 1'b1;
                for (int c = 0; c < NCH; c++) begin
                    m_cur[c] <= toward(m_cur[c], m_tgt[c]);
                    m_en[c]  <= ch_en[c];
                end
            end else begin
                m_cnt <= m_cnt + 1;
                m_fs  <= 1'b0;
            end
            if (wr_en && int'(wr_ch) < NCH) m_tgt[wr_ch] <= clampv(int'(wr_data));
        end
    end

    function automatic logic [NCH-1:0] exp_servo();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_en[c] && (m_cnt < m_cur[c]);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_busy();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = (m_cur[c] != m_tgt[c]);
        return v;
    endfunction

    // ---------------- stimulus / measurement utilities ---------------------
    task automatic do_write(input int ch, input int data);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_data = CW'(data);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_cnt(input int target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_cnt != target && n < 3 * P);
        if (m_cnt != target) begin
            checks++; failures++;
            $display("FAIL wait_cnt: timed out, cnt=%0d required=%0d", m_cnt, target);
        end
    endtask

    // Measures one frame starting at the next frame_start: per-channel high
    // count, whether each pulse starts at cycle 0 and is contiguous, and
    // whether frame_start shows up exactly one period later and nowhere else.
    task automatic measure_frame(output int w [NCH], output bit shape_ok,
                                 output bit fs_ok, output bit timed_out);
        int n = 0;
        timed_out = 1'b0;
        shape_ok  = 1'b1;
        fs_ok     = 1'b1;
        for (int c = 0; c < NCH; c++) w[c] = 0;
        while (frame_start !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 3 * P) begin
                timed_out = 1'b1;
                return;
            end
        end
        for (int k = 0; k < P; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if (servo[c] === 1'b1) begin
                    if (w[c] != k) shape_ok = 1'b0;
                    w[c]++;
                end
            end
            if (k > 0 && frame_start !== 1'b0) fs_ok = 1'b0;
            @(negedge clk);
        end
        if (frame_start !== 1'b1) fs_ok = 1'b0;
    endtask

    // ---------------- scenarios ---------------------------------------------
    task automatic test_reset();
        int n = 0;
        bit any_high = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (servo !== 4'h0) begin failures++; $display("FAIL reset_servo: got %b want 0000", servo); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs: got %b want 0", frame_start); end
        checks++; if (busy !== 4'h0) begin failures++; $display("FAIL reset_busy: got %b want 0000", busy); end
        rst_n = 1'b1;
        while (frame_start !== 1'b1 && n < 3 * P) begin
            @(negedge clk);
            n++;
            if (servo !== 4'h0 && frame_start !== 1'b1) any_high = 1'b1;
        end
        checks++; if (n != P) begin failures++; $display("FAIL first_fs_delay: got %0d cycles want %0d", n, P); end
        checks++; if (any_high) begin failures++; $display("FAIL first_frame_servo: got activity want none"); end
    endtask

    task automatic test_frames();
        int w [NCH]; bit sh, fo, to;
        measure_frame(w, sh, fo, to);
        checks++; if (to) begin failures++; $display("FAIL frames_timeout: no frame_start"); end
        for (int c = 0; c < NCH; c++) begin
            checks++; if (w[c] != MIDV) begin failures++; $display("FAIL frames_width ch%0d: got %0d want %0d", c, w[c], MIDV); end
        end
        checks++; if (!sh || !fo) begin failures++; $display("FAIL frames_shape: shape=%0d fs=%0d want 1 1", sh, fo); end
        checks++; if (busy !== 4'h0) begin failures++; $display("FAIL frames_busy: got %b want 0000", busy); end
    endtask

    task automatic test_slew_up();
        int w [NCH]; bit sh, fo, to;
        int exp1 [3] = '{19, 23, 25};
        do_write(1, 25);
        checks++; if (busy !== 4'b0010) begin failures++; $display("FAIL slew_busy_set: got %b want 0010", busy); end
        for (int f = 0; f < 3; f++) begin
            measure_frame(w, sh, fo, to);
            checks++; if (to || w[1] != exp1[f] || w[0] != MIDV || w[2] != MIDV || w[3] != MIDV) begin
                failures++;
                $display("FAIL slew_up f%0d: got ch0..3=%0d %0d %0d %0d want 15 %0d 15 15", f, w[0], w[1], w[2], w[3], exp1[f]);
            end
            if (f == 0) begin
                checks++; if (busy[1] !== 1'b1) begin failures++; $display("FAIL slew_busy_mid: got %b want 1", busy[1]); end
            end
            if (f == 1) begin
                checks++; if (busy[1] !== 1'b0) begin failures++; $display("FAIL slew_busy_clear: got %b want 0", busy[1]); end
            end
        end
    endtask

    task automatic test_clamp();
        int w [NCH]; bit sh, fo, to;
        int e2 [3] = '{19, 23, 25};
        int e3 [3] = '{11, 7, 5};
        do_write(2, 200);
        do_write(3, 0);
        checks++; if (busy !== 4'b1100) begin failures++; $display("FAIL clamp_busy: got %b want 1100", busy); end
        for (int f = 0; f < 3; f++) begin
            measure_frame(w, sh, fo, to);
            checks++; if (to || w[2] != e2[f] || w[3] != e3[f] || w[1] != MAXV || w[0] != MIDV) begin
                failures++;
                $display("FAIL clamp f%0d: got ch0..3=%0d %0d %0d %0d want 15 25 %0d %0d", f, w[0], w[1], w[2], w[3], e2[f], e3[f]);
            end
        end
        checks++; if (busy !== 4'h0) begin failures++; $display("FAIL clamp_settled: got %b want 0000", busy); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        bit any_high = 1'b0;
        wait_cnt(10);
        checks++; if (servo !== 4'b0111) begin failures++; $display("FAIL ares_pre: got %b want 0111", servo); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (servo !== 4'h0) begin failures++; $display("FAIL ares_servo: got %b want 0000", servo); end
        checks++; if (frame_start !== 1'b0 || busy !== 4'h0) begin failures++; $display("FAIL ares_state: got fs=%b busy=%b want 0 0000", frame_start, busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        while (frame_start !== 1'b1 && n < 3 * P) begin
            @(negedge clk);
            n++;
            if (servo !== 4'h0 && frame_start !== 1'b1) any_high = 1'b1;
        end
        checks++; if (n != P || any_high) begin failures++; $display("FAIL ares_restart: got %0d cycles high=%0d want %0d 0", n, any_high, P); end
        checks++; if (busy !== 4'h0 || servo !== 4'hF) begin failures++; $display("FAIL ares_mid: got busy=%b servo=%b want 0000 1111", busy, servo); end
    endtask

    task automatic test_boundary_write();
        int w [NCH]; bit sh, fo, to;
        int e1 [3] = '{25, 21, 17};
        do_write(1, 17);
        wait_cnt(P - 1);
        @(negedge clk);
        do_write(1, 3);
        do_write(1, 25);
        wait_cnt(P - 1);
        @(negedge clk);
        checks++; if (busy[1] !== 1'b1 || m_cur[1] != 21) begin failures++; $display("FAIL bnd_setup: got busy=%b cur=%0d want 1 21", busy[1], m_cur[1]); end
        wait_cnt(P - 1);
        do_write(1, 5);
        checks++; if (busy[1] !== 1'b1 || frame_start !== 1'b1) begin failures++; $display("FAIL bnd_write: got busy=%b fs=%b want 1 1", busy[1], frame_start); end
        for (int f = 0; f < 3; f++) begin
            measure_frame(w, sh, fo, to);
            checks++; if (to || w[1] != e1[f] || !sh) begin failures++; $display("FAIL bnd_slew f%0d: got %0d want %0d", f, w[1], e1[f]); end
        end
    endtask

    task automatic test_enable_toggle();
        int w [NCH]; bit sh, fo, to;
        int hi = 0;
        wait_cnt(7);
        ch_en[0] = 1'b0;
        for (int k = 7; k < P; k++) begin
            if (servo[0] === 1'b1) hi++;
            @(negedge clk);
        end
        checks++; if (hi != MIDV - 7) begin failures++; $display("FAIL en_off_same_frame: got %0d want %0d", hi, MIDV - 7); end
        measure_frame(w, sh, fo, to);
        checks++; if (to || w[0] != 0 || w[2] != MIDV) begin failures++; $display("FAIL en_off_next: got ch0=%0d ch2=%0d want 0 15", w[0], w[2]); end
        wait_cnt(7);
        ch_en[0] = 1'b1;
        hi = 0;
        for (int k = 7; k < P; k++) begin
            if (servo[0] === 1'b1) hi++;
            @(negedge clk);
        end
        checks++; if (hi != 0) begin failures++; $display("FAIL en_on_same_frame: got %0d want 0", hi); end
        measure_frame(w, sh, fo, to);
        checks++; if (to || w[0] != MIDV || !sh) begin failures++; $display("FAIL en_on_next: got %0d shape=%0d want 15 1", w[0], sh); end
    endtask

    task automatic test_random();
        logic [NCH-1:0] es, eb;
        for (int cyc = 0; cyc < 8 * P; cyc++) begin
            es = exp_servo();
            eb = exp_busy();
            checks++; if (servo !== es) begin failures++; $display("FAIL rand_servo @%0d: got %b want %b", cyc, servo, es); end
            checks++; if (busy !== eb) begin failures++; $display("FAIL rand_busy @%0d: got %b want %b", cyc, busy, eb); end
            checks++; if (frame_start !== m_fs) begin failures++; $display("FAIL rand_fs @%0d: got %b want %b", cyc, frame_start, m_fs); end
            wr_en   = ($urandom_range(0, 9) == 0);
            wr_ch   = 2'($urandom_range(0, 3));
            wr_data = CW'($urandom_range(0, 255));
            if ($urandom_range(0, 39) == 0) ch_en = 4'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_frames();
        test_slew_up();
        test_clamp();
        test_async_reset();
        test_boundary_write();
        test_enable_toggle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
